// File: rtl/quad_encoder_decoder.sv
// Quadrature encoder front end: per-channel synchronizer, glitch filter and Gray-code step decoder.
// Defining QUAD_INDEX_EN adds the index channel (enc_z in, index_pulse out) that zeroes the position.
module quad_encoder_decoder #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int POS_WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enc_a,
    input  logic                 enc_b,
`ifdef QUAD_INDEX_EN
    input  logic                 enc_z,
    output logic                 index_pulse,
`endif
    input  logic                 error_clr,
    output logic                 state_change,
    output logic                 direction,
    output logic [POS_WIDTH-1:0] position,
    output logic                 error
);

`ifdef QUAD_INDEX_EN
    localparam int NCH = 3;
`else
    localparam int NCH = 2;
`endif
    localparam int CNT_W       = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam int INIT_CYCLES = SYNC_STAGES + FILTER_CYCLES + 1;
    localparam int INIT_W      = $clog2(INIT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  FILT_LAST = CNT_W'(FILTER_CYCLES - 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

    typedef enum logic {INIT = 1'b0, TRACK = 1'b1} mode_t;

    // Forward Gray sequence 00 -> 10 -> 11 -> 01 -> 00 on {a,b}
    function automatic logic [1:0] fwd_next(input logic [1:0] s);
        case (s)
            2'b00:   fwd_next = 2'b10;
            2'b10:   fwd_next = 2'b11;
            2'b11:   fwd_next = 2'b01;
            2'b01:   fwd_next = 2'b00;
            default: fwd_next = 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] rev_next(input logic [1:0] s);
        case (s)
            2'b00:   rev_next = 2'b01;
            2'b01:   rev_next = 2'b11;
            2'b11:   rev_next = 2'b10;
            2'b10:   rev_next = 2'b00;
            default: rev_next = 2'b00;
        endcase
    endfunction

    logic [NCH-1:0] raw_s;
    logic [NCH-1:0] filt_s;

`ifdef QUAD_INDEX_EN
    assign raw_s = {enc_z, enc_b, enc_a};
`else
    assign raw_s = {enc_b, enc_a};
`endif

    genvar ch;
    generate
        for (ch = 0; ch < NCH; ch++) begin : g_chan
            logic [SYNC_STAGES-1:0] sync_r;
            logic [CNT_W-1:0]       cnt_r;
            logic                   filt_r;
            logic                   synced_s;

            assign synced_s   = sync_r[SYNC_STAGES-1];
            assign filt_s[ch] = filt_r;

            // Synchronizer chain for the asynchronous raw input
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync_r <= '0;
                end else begin
                    sync_r <= {sync_r[SYNC_STAGES-2:0], raw_s[ch]};
                end
            end

            // Accept a new level only after it persists; any bounce back restarts the count
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    filt_r <= 1'b0;
                    cnt_r  <= '0;
                end else if (synced_s == filt_r) begin
                    cnt_r <= '0;
                end else if (cnt_r == FILT_LAST) begin
                    filt_r <= synced_s;
                    cnt_r  <= '0;
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end
        end
    endgenerate

    mode_t             mode_r;
    mode_t             mode_next_s;
    logic [INIT_W-1:0] init_cnt_r;

    // Mode register and startup counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_r     <= INIT;
            init_cnt_r <= '0;
        end else begin
            mode_r <= mode_next_s;
            if (mode_r == INIT) begin
                init_cnt_r <= init_cnt_r + INIT_W'(1);
            end
        end
    end

    // Leave INIT once the pipeline has flushed the reset-time levels
    always_comb begin
        mode_next_s = mode_r;
        case (mode_r)
            INIT: begin
                if (init_cnt_r == INIT_LAST) begin
                    mode_next_s = TRACK;
                end else begin
                    mode_next_s = INIT;
                end
            end
            TRACK:   mode_next_s = TRACK;
            default: mode_next_s = INIT;
        endcase
    end

    logic [1:0]           ab_s;
    logic [1:0]           state_r;
    logic                 step_fwd_s;
    logic                 step_rev_s;
    logic                 illegal_s;
    logic                 index_s;
    logic                 state_change_r;
    logic                 direction_r;
    logic [POS_WIDTH-1:0] position_r;
    logic                 error_r;

    assign ab_s = {filt_s[0], filt_s[1]};

    // Classify the filtered {a,b} against the stored state
    always_comb begin
        step_fwd_s = 1'b0;
        step_rev_s = 1'b0;
        illegal_s  = 1'b0;
        if (mode_r == TRACK) begin
            if (ab_s == fwd_next(state_r)) begin
                step_fwd_s = 1'b1;
            end else if (ab_s == rev_next(state_r)) begin
                step_rev_s = 1'b1;
            end else if (ab_s != state_r) begin
                illegal_s = 1'b1;
            end else begin
                illegal_s = 1'b0;
            end
        end else begin
            illegal_s = 1'b0;
        end
    end

`ifdef QUAD_INDEX_EN
    logic z_prev_r;
    logic index_pulse_r;

    assign index_s     = (mode_r == TRACK) && filt_s[2] && !z_prev_r;
    assign index_pulse = index_pulse_r;

    // Index edge detector on the filtered Z level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z_prev_r      <= 1'b0;
            index_pulse_r <= 1'b0;
        end else begin
            z_prev_r      <= filt_s[2];
            index_pulse_r <= index_s;
        end
    end
`else
    assign index_s = 1'b0;
`endif

    // Decode state, step outputs, position counter and sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= 2'b00;
            state_change_r <= 1'b0;
            direction_r    <= 1'b0;
            position_r     <= '0;
            error_r        <= 1'b0;
        end else begin
            state_r        <= ab_s;
            state_change_r <= step_fwd_s | step_rev_s;
            if (step_fwd_s) begin
                direction_r <= 1'b1;
            end else if (step_rev_s) begin
                direction_r <= 1'b0;
            end
            // Index has priority over a coincident step
            if (index_s) begin
                position_r <= '0;
            end else if (step_fwd_s) begin
                position_r <= position_r + POS_WIDTH'(1);
            end else if (step_rev_s) begin
                position_r <= position_r - POS_WIDTH'(1);
            end
            if (illegal_s) begin
                error_r <= 1'b1;
            end else if (error_clr) begin
                error_r <= 1'b0;
            end
        end
    end

    assign state_change = state_change_r;
    assign direction    = direction_r;
    assign position     = position_r;
    assign error        = error_r;

endmodule

// File: tb/tb_quad_encoder_decoder.sv
// Self-checking bench for quad_encoder_decoder: directed test-plan scenarios plus random
// A/B/Z activity, all compared every cycle against a phase-arithmetic reference model.
module tb_quad_encoder_decoder;
    localparam int D        = 2;
    localparam int F        = 4;
    localparam int W        = 32;
    localparam int INIT_LEN = D + F + 1;
    localparam int LAT      = D + F + 1;

    logic         clk       = 1'b0;
    logic         reset     = 1'b1;
    logic         enc_a     = 1'b1;
    logic         enc_b     = 1'b1;
    logic         enc_z     = 1'b0;
    logic         error_clr = 1'b0;
    logic         state_change;
    logic         direction;
    logic         error;
    logic [W-1:0] position;
    logic         index_pulse;

    int checks    = 0;
    int errors    = 0;
    int sc_count  = 0;
    int idx_count = 0;
    int cur_ph    = 0;

    // Reference model state
    logic [63:0]  hist [3];
    logic [2:0]   mf      = 3'b000;
    logic [1:0]   mstate  = 2'b00;
    logic [1:0]   nab     = 2'b00;
    logic         mz      = 1'b0;
    logic         rb      = 1'b0;
    logic         allnew  = 1'b0;
    int           cyc     = 0;
    int           d       = 0;
    logic         exp_sc  = 1'b0;
    logic         exp_dir = 1'b0;
    logic         exp_err = 1'b0;
    logic         exp_idx = 1'b0;
    logic [W-1:0] exp_pos = '0;

    quad_encoder_decoder #(
        .SYNC_STAGES  (D),
        .FILTER_CYCLES(F),
        .POS_WIDTH    (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enc_a       (enc_a),
        .enc_b       (enc_b),
`ifdef QUAD_INDEX_EN
        .enc_z       (enc_z),
        .index_pulse (index_pulse),
`endif
        .error_clr   (error_clr),
        .state_change(state_change),
        .direction   (direction),
        .position    (position),
        .error       (error)
    );

`ifndef QUAD_INDEX_EN
    assign index_pulse = 1'b0;
`endif

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Position of a Gray code {a,b} along the forward cycle
    function automatic int phase_of(input logic [1:0] ab);
        case (ab)
            2'b00:   phase_of = 0;
            2'b10:   phase_of = 1;
            2'b11:   phase_of = 2;
            default: phase_of = 3;
        endcase
    endfunction

    function automatic logic [1:0] gray_of(input int ph);
        case (ph)
            0:       gray_of = 2'b00;
            1:       gray_of = 2'b10;
            2:       gray_of = 2'b11;
            default: gray_of = 2'b01;
        endcase
    endfunction

    // Reference model: a level is accepted once its last F synced samples all disagree with
    // the filtered level; steps are the phase difference modulo 4.
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            for (int c = 0; c < 3; c++) hist[c] = 64'd0;
            mf = 3'b000; mstate = 2'b00; mz = 1'b0; cyc = 0;
            exp_sc = 1'b0; exp_dir = 1'b0; exp_err = 1'b0; exp_idx = 1'b0; exp_pos = '0;
        end else begin
            cyc++;
            nab    = {mf[0], mf[1]};
            d      = (phase_of(nab) - phase_of(mstate) + 4) % 4;
            exp_sc = 1'b0;
            exp_idx = 1'b0;
            if (cyc > INIT_LEN) begin
                if (d == 1) begin
                    exp_sc = 1'b1; exp_dir = 1'b1; exp_pos = exp_pos + 32'd1;
                end else if (d == 3) begin
                    exp_sc = 1'b1; exp_dir = 1'b0; exp_pos = exp_pos - 32'd1;
                end
                if (mf[2] && !mz) begin
                    exp_pos = '0; exp_idx = 1'b1;
                end
                if (d == 2) exp_err = 1'b1;
                else if (error_clr) exp_err = 1'b0;
            end else if (error_clr) begin
                exp_err = 1'b0;
            end
            mstate = nab;
            mz     = mf[2];
            for (int c = 0; c < 3; c++) begin
                rb      = (c == 0) ? enc_a : ((c == 1) ? enc_b : enc_z);
                hist[c] = {hist[c][62:0], rb};
                allnew  = 1'b1;
                for (int k = D; k < D + F; k++) if (hist[c][k] == mf[c]) allnew = 1'b0;
                if (allnew) mf[c] = ~mf[c];
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        check("state_change", 64'(state_change), 64'(exp_sc));
        check("direction",    64'(direction),    64'(exp_dir));
        check("position",     64'(position),     64'(exp_pos));
        check("error",        64'(error),        64'(exp_err));
`ifdef QUAD_INDEX_EN
        check("index_pulse",  64'(index_pulse),  64'(exp_idx));
`endif
        if (state_change) sc_count++;
        if (index_pulse) idx_count++;
    end

    task automatic wait_pulse(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!state_change && k < 30);
    endtask

    task automatic drive_step(input int delta, input string tag, input int hold);
        int k;
        cur_ph = (cur_ph + delta + 4) % 4;
        {enc_a, enc_b} = gray_of(cur_ph);
        wait_pulse(k);
        check(tag, 64'(k), 64'(LAT));
        repeat (hold - k) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_rst_pos", 64'(position),     64'd0);
        check("async_rst_dir", 64'(direction),    64'd0);
        check("async_rst_sc",  64'(state_change), 64'd0);
        check("async_rst_err", 64'(error),        64'd0);
        {enc_a, enc_b} = 2'b00;
        cur_ph = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int sc0;
        int n;
        // Startup with 11 held: INIT absorbs it silently
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("init_no_pulse", 64'(sc_count), 64'd0);
        check("init_pos",      64'(position), 64'd0);
        check("init_err",      64'(error),    64'd0);
        cur_ph = 2;
        drive_step(1, "first_step_latency", 20);
        check("first_step_pos", 64'(position),  64'd1);
        check("first_step_dir", 64'(direction), 64'd1);

        // Forward rotation
        do_reset();
        sc0 = sc_count;
        for (int i = 0; i < 4; i++) drive_step(1, "fwd_latency", 20);
        check("fwd_pulses", 64'(sc_count - sc0), 64'd4);
        check("fwd_pos",    64'(position),  64'd4);
        check("fwd_dir",    64'(direction), 64'd1);
        check("fwd_err",    64'(error),     64'd0);

        // Reverse through zero
        do_reset();
        for (int i = 0; i < 3; i++) drive_step(-1, "rev_latency", 20);
        check("rev_pos", 64'(position),  64'h0000_0000_FFFF_FFFD);
        check("rev_dir", 64'(direction), 64'd0);

        // Glitch rejection
        do_reset();
        sc0 = sc_count;
        enc_a = 1'b1; repeat (3) @(negedge clk);
        enc_a = 1'b0; repeat (20) @(negedge clk);
        check("glitch3_pulses", 64'(sc_count - sc0), 64'd0);
        check("glitch3_pos",    64'(position), 64'd0);
        enc_a = 1'b1; repeat (4) @(negedge clk);
        enc_a = 1'b0; repeat (20) @(negedge clk);
        check("glitch4_pulses", 64'(sc_count - sc0), 64'd2);
        check("glitch4_pos",    64'(position),  64'd0);
        check("glitch4_dir",    64'(direction), 64'd0);

        // Illegal transitions and error clearing
        sc0 = sc_count;
        {enc_a, enc_b} = 2'b11; repeat (20) @(negedge clk);
        check("illegal_err",    64'(error),    64'd1);
        check("illegal_pulses", 64'(sc_count - sc0), 64'd0);
        check("illegal_pos",    64'(position), 64'd0);
        {enc_a, enc_b} = 2'b00;
        repeat (LAT - 1) @(negedge clk);
        error_clr = 1'b1;
        @(negedge clk);
        error_clr = 1'b0;
        check("set_beats_clr", 64'(error), 64'd1);
        repeat (10) @(negedge clk);
        error_clr = 1'b1;
        @(negedge clk);
        error_clr = 1'b0;
        check("lone_clr", 64'(error), 64'd0);
        cur_ph = 0;

`ifdef QUAD_INDEX_EN
        // Index at position 57, then index coincident with a step
        for (int i = 0; i < 57; i++) drive_step(1, "idx_rot_latency", 10);
        check("idx_pre_pos", 64'(position), 64'd57);
        n = idx_count;
        enc_z = 1'b1; repeat (20) @(negedge clk);
        check("idx_pos",    64'(position), 64'd0);
        check("idx_pulses", 64'(idx_count - n), 64'd1);
        enc_z = 1'b0; repeat (20) @(negedge clk);
        drive_step(1, "pre_coinc_latency", 20);
        cur_ph = (cur_ph + 1) % 4;
        {enc_a, enc_b} = gray_of(cur_ph);
        enc_z = 1'b1;
        wait_pulse(n);
        check("coinc_latency", 64'(n), 64'(LAT));
        check("coinc_idx",     64'(index_pulse), 64'd1);
        check("coinc_pos",     64'(position),    64'd0);
        check("coinc_sc",      64'(state_change), 64'd1);
        enc_z = 1'b0;
        repeat (20) @(negedge clk);
`endif

        // Random activity including illegal jumps, glitches and error clears
        repeat (250) begin
            {enc_a, enc_b} = 2'($urandom_range(0, 3));
`ifdef QUAD_INDEX_EN
            if ($urandom_range(0, 7) == 0) enc_z = ~enc_z;
`endif
            n = $urandom_range(1, 12);
            repeat (n) begin
                error_clr = ($urandom_range(0, 15) == 0);
                @(negedge clk);
            end
        end
        error_clr = 1'b0;
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
